// File: rtl/query_port_arbiter_if.sv
// rtl/query_port_arbiter_if.sv - requester, RAM query and response signals of the query port arbiter
interface query_port_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int READ_NUM_WIDTH = 6
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [6*NUM_REQ-1:0]        req_status;
  logic [7*NUM_REQ-1:0]        req_position;
  logic [READ_NUM_WIDTH*NUM_REQ-1:0] req_read_num;
  logic [NUM_REQ-1:0]          req_ready;
  logic [5:0]                  status_query;
  logic [6:0]                  query_position;
  logic [READ_NUM_WIDTH-1:0]   query_read_num;
  logic [7:0]                  new_read_query;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [7:0]                  rsp_data;
  logic [6:0]                  rsp_position;
  logic [READ_NUM_WIDTH-1:0]   rsp_read_num;
  logic [1:0]                  inflight;

  modport master (
    output req_valid, req_status, req_position, req_read_num, new_read_query,
    input  req_ready, status_query, query_position, query_read_num,
           rsp_valid, rsp_data, rsp_position, rsp_read_num, inflight
  );

  modport slave (
    input  req_valid, req_status, req_position, req_read_num, new_read_query,
    output req_ready, status_query, query_position, query_read_num,
           rsp_valid, rsp_data, rsp_position, rsp_read_num, inflight
  );
endinterface

// File: rtl/query_port_arbiter.sv
// rtl/query_port_arbiter.sv - round-robin sharing of the RAM read-query port with tagged response routing
module query_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int READ_NUM_WIDTH = 6,
  parameter int LATENCY        = 3
) (
  input logic clk,
  input logic reset,
  input logic stall,
  query_port_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [5:0] BUBBLE = 6'b110000;

  logic [NUM_REQ-1:0]        eligible;
  logic                      win_found;
  logic [IDW-1:0]            win_idx;
  logic [IDW-1:0]            cand;
  logic                      grant;
  logic [IDW-1:0]            rr_q, rr_d;

  logic                      v_q   [LATENCY];
  logic [IDW-1:0]            id_q  [LATENCY];
  logic [6:0]                pos_q [LATENCY];
  logic [READ_NUM_WIDTH-1:0] rn_q  [LATENCY];

  logic                      rsp_fire;
  logic [1:0]                inflight_cnt;

  always_comb begin
    eligible  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (bus.req_status[6*i +: 6] != BUBBLE);
    end
    // Search starts just after the last winner, so the last winner has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant = win_found && !stall && !reset;
  assign rr_d  = grant ? win_idx : rr_q;

  assign bus.req_ready      = grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign bus.status_query   = grant ? bus.req_status[6*win_idx +: 6] : BUBBLE;
  assign bus.query_position = grant ? bus.req_position[7*win_idx +: 7] : 7'd0;
  assign bus.query_read_num = grant ? bus.req_read_num[READ_NUM_WIDTH*win_idx +: READ_NUM_WIDTH]
                                    : '0;

  // Shadow pipeline mirrors the RAM's extraction stages, including its stall behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= IDW'(NUM_REQ - 1);
      for (int s = 0; s < LATENCY; s++) begin
        v_q[s]   <= 1'b0;
        id_q[s]  <= '0;
        pos_q[s] <= '0;
        rn_q[s]  <= '0;
      end
    end else if (!stall) begin
      rr_q     <= rr_d;
      v_q[0]   <= grant;
      id_q[0]  <= win_idx;
      pos_q[0] <= bus.query_position;
      rn_q[0]  <= bus.query_read_num;
      for (int s = 1; s < LATENCY; s++) begin
        v_q[s]   <= v_q[s-1];
        id_q[s]  <= id_q[s-1];
        pos_q[s] <= pos_q[s-1];
        rn_q[s]  <= rn_q[s-1];
      end
    end
  end

  assign rsp_fire = v_q[LATENCY-1] && !stall && !reset;

  assign bus.rsp_valid    = rsp_fire ? (NUM_REQ'(1) << id_q[LATENCY-1]) : '0;
  assign bus.rsp_data     = rsp_fire ? bus.new_read_query : 8'hFF;
  assign bus.rsp_position = rsp_fire ? pos_q[LATENCY-1] : 7'd0;
  assign bus.rsp_read_num = rsp_fire ? rn_q[LATENCY-1] : '0;

  always_comb begin
    inflight_cnt = '0;
    for (int s = 0; s < LATENCY; s++) begin
      inflight_cnt = inflight_cnt + 2'(v_q[s]);
    end
  end

  assign bus.inflight = inflight_cnt;
endmodule

// File: tb/tb_query_port_arbiter.sv
// tb/tb_query_port_arbiter.sv - directed and random checks of query_port_arbiter against a queue model
module tb_query_port_arbiter;
  localparam int N  = 4;
  localparam int RW = 6;
  localparam int L  = 3;
  localparam logic [5:0] BUBBLE = 6'b110000;

  logic clk = 1'b0;
  logic reset;
  logic stall;

  query_port_arbiter_if #(.NUM_REQ(N), .READ_NUM_WIDTH(RW)) qif();

  query_port_arbiter #(.NUM_REQ(N), .READ_NUM_WIDTH(RW), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .bus   (qif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(logic [RW-1:0] rn, logic [6:0] pos);
    int v;
    v = int'(rn) * 37 + int'(pos) * 11 + 90;
    return v[7:0];
  endfunction

  // RAM: registered data, LATENCY non-stalled edges after the query is presented.
  logic [7:0] ram_pipe [L];
  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < L; s++) ram_pipe[s] <= 8'hFF;
    end else if (!stall) begin
      for (int s = L - 1; s > 0; s--) ram_pipe[s] <= ram_pipe[s-1];
      ram_pipe[0] <= (qif.status_query != BUBBLE) ?
                     mem_byte(qif.query_read_num, qif.query_position) : 8'hFF;
    end
  end
  assign qif.new_read_query = ram_pipe[L-1];

  typedef struct {
    int id;
    int pos;
    int rn;
    int age;
  } entry_t;

  entry_t fly[$];
  int last_win = N - 1;
  int exp_win;
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int idx;
    int rsp_idx;
    logic [31:0] e_ready, e_st, e_pos, e_rn;
    exp_win = -1;
    if (!reset && !stall) begin
      for (int k = 1; k <= N; k++) begin
        idx = (last_win + k) % N;
        if (exp_win < 0 && qif.req_valid[idx] && qif.req_status[6*idx +: 6] != BUBBLE)
          exp_win = idx;
      end
    end
    if (exp_win < 0) begin
      e_ready = 0; e_st = 32'(BUBBLE); e_pos = 0; e_rn = 0;
    end else begin
      e_ready = 32'(1) << exp_win;
      e_st    = 32'(qif.req_status[6*exp_win +: 6]);
      e_pos   = 32'(qif.req_position[7*exp_win +: 7]);
      e_rn    = 32'(qif.req_read_num[RW*exp_win +: RW]);
    end
    chk("req_ready", 32'(qif.req_ready), e_ready);
    chk("status_query", 32'(qif.status_query), e_st);
    chk("query_position", 32'(qif.query_position), e_pos);
    chk("query_read_num", 32'(qif.query_read_num), e_rn);

    rsp_idx = -1;
    foreach (fly[j]) if (fly[j].age == L) rsp_idx = j;
    if (reset || stall) rsp_idx = -1;
    if (rsp_idx < 0) begin
      chk("rsp_valid", 32'(qif.rsp_valid), 0);
      chk("rsp_data", 32'(qif.rsp_data), 32'hFF);
      chk("rsp_position", 32'(qif.rsp_position), 0);
      chk("rsp_read_num", 32'(qif.rsp_read_num), 0);
    end else begin
      chk("rsp_valid", 32'(qif.rsp_valid), 32'(1) << fly[rsp_idx].id);
      chk("rsp_data", 32'(qif.rsp_data),
          32'(mem_byte(RW'(fly[rsp_idx].rn), 7'(fly[rsp_idx].pos))));
      chk("rsp_position", 32'(qif.rsp_position), 32'(fly[rsp_idx].pos));
      chk("rsp_read_num", 32'(qif.rsp_read_num), 32'(fly[rsp_idx].rn));
    end
    chk("inflight", 32'(qif.inflight), 32'(fly.size()));
  endtask

  task automatic update_model();
    entry_t keep[$];
    entry_t e;
    if (reset) begin
      fly.delete();
      last_win = N - 1;
    end else if (!stall) begin
      foreach (fly[j]) begin
        e = fly[j];
        e.age++;
        if (e.age <= L) keep.push_back(e);
      end
      if (exp_win >= 0) begin
        e.id  = exp_win;
        e.pos = int'(qif.req_position[7*exp_win +: 7]);
        e.rn  = int'(qif.req_read_num[RW*exp_win +: RW]);
        e.age = 1;
        keep.push_back(e);
        last_win = exp_win;
      end
      fly = keep;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_req(int i, logic v, logic [5:0] s, logic [6:0] p, logic [RW-1:0] r);
    qif.req_valid[i]             = v;
    qif.req_status[6*i +: 6]     = s;
    qif.req_position[7*i +: 7]   = p;
    qif.req_read_num[RW*i +: RW] = r;
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 6'h5, 7'd0, '0);
  endtask

  task automatic all_valid(int base);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'h5, 7'(base + 10 * i), RW'(i + 1));
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    step();

    set_req(1, 1'b1, 6'h5, 7'd37, 6'd5);
    step();
    idle();
    repeat (5) step();

    for (int c = 0; c < 8; c++) begin
      all_valid(c * 3);
      step();
    end
    idle();
    repeat (4) step();

    all_valid(50);
    repeat (3) step();
    stall = 1'b1;
    repeat (4) step();
    stall = 1'b0;
    idle();
    repeat (5) step();

    set_req(2, 1'b1, BUBBLE, 7'd20, 6'd2);
    set_req(3, 1'b1, 6'h5, 7'd30, 6'd3);
    step();
    set_req(3, 1'b0, 6'h5, 7'd30, 6'd3);
    step();
    idle();
    repeat (4) step();

    all_valid(90);
    repeat (2) step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) step();
    all_valid(100);
    step();
    idle();
    repeat (4) step();

    for (int c = 0; c < 5; c++) begin
      set_req(0, 1'b1, 6'h5, 7'(60 + c), 6'(c));
      step();
    end
    idle();
    repeat (5) step();

    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? BUBBLE : 6'($urandom_range(0, 63)),
                7'($urandom), RW'($urandom));
      end
      step();
    end
    reset = 1'b0;
    stall = 1'b0;
    idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
